// File: rtl/inst_fetch_unit.sv
// Fetch-stage front end: PC register, single-outstanding instruction fetch and a small
// instruction buffer feeding decode over a valid/ready handshake, with redirect squashing.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_r;
    logic [31:0]        pc_r;
    logic [31:0]        req_pc_r;
    logic [31:0]        buf_instr_r [FIFO_DEPTH];
    logic [31:0]        buf_pc_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W:0]     count_r;
    logic               id_valid_r;
    logic [31:0]        id_instr_r;
    logic [31:0]        id_pc_r;

    logic               pop_s;
    logic               credit_s;
    logic               inst_req_s;
    logic               addr_acc_s;
    logic               push_s;
    logic [PTR_W:0]     count_after_pop_s;
    logic [PTR_W:0]     count_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [31:0]        head_instr_s;
    logic [31:0]        head_pc_s;

    // Handshake qualifiers; a same-cycle dequeue frees a slot for the credit check.
    always_comb begin
        pop_s      = id_valid_r & id_ready;
        credit_s   = (count_r < DEPTH_C) | pop_s;
        inst_req_s = resetn & (state_r == ST_REQ) & credit_s;
        addr_acc_s = inst_req_s & inst_addr_ok;
        push_s     = (state_r == ST_WAIT) & inst_data_ok & ~redirect_valid;
    end

    // Next buffer occupancy/pointers and the head word decode will see next cycle.
    always_comb begin
        count_after_pop_s = count_r - (PTR_W+1)'(pop_s);
        head_instr_s      = id_instr_r;
        head_pc_s         = id_pc_r;
        if (redirect_valid) begin
            count_nxt_s  = (PTR_W+1)'(0);
            rd_ptr_nxt_s = PTR_W'(0);
            wr_ptr_nxt_s = PTR_W'(0);
        end else begin
            count_nxt_s  = count_after_pop_s + (PTR_W+1)'(push_s);
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_s);
        end
        // An empty buffer keeps showing the last head; a push into an empty slot goes straight to the head.
        if (count_nxt_s != (PTR_W+1)'(0)) begin
            if (count_after_pop_s == (PTR_W+1)'(0)) begin
                head_instr_s = inst_rdata;
                head_pc_s    = req_pc_r;
            end else begin
                head_instr_s = buf_instr_r[rd_ptr_nxt_s];
                head_pc_s    = buf_pc_r[rd_ptr_nxt_s];
            end
        end else begin
            head_instr_s = id_instr_r;
            head_pc_s    = id_pc_r;
        end
    end

    // Buffer storage; contents are qualified by count_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_instr_r[wr_ptr_r] <= inst_rdata;
            buf_pc_r[wr_ptr_r]    <= req_pc_r;
        end
    end

    // Fetch FSM, PC, buffer bookkeeping and registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_REQ;
            pc_r       <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
            rd_ptr_r   <= PTR_W'(0);
            wr_ptr_r   <= PTR_W'(0);
            count_r    <= (PTR_W+1)'(0);
            id_valid_r <= 1'b0;
            id_instr_r <= 32'h0000_0000;
            id_pc_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (addr_acc_s) begin
                        req_pc_r <= pc_r;
                        state_r  <= redirect_valid ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        state_r <= ST_REQ;
                    end else if (redirect_valid) begin
                        state_r <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (inst_data_ok) begin
                        state_r <= ST_REQ;
                    end
                end
                default: state_r <= ST_REQ;
            endcase

            if (redirect_valid) begin
                pc_r <= redirect_pc;
            end else if (addr_acc_s) begin
                pc_r <= pc_r + 32'd4;
            end

            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            count_r    <= count_nxt_s;
            id_valid_r <= (count_nxt_s != (PTR_W+1)'(0));
            id_instr_r <= head_instr_s;
            id_pc_r    <= head_pc_s;
        end
    end

    assign inst_req  = inst_req_s;
    assign inst_addr = pc_r;
    assign id_valid  = id_valid_r;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;

endmodule
